// File: rtl/bcd_display_pkg.sv
// Shared types and segment constants for the BCD display controller.
// Segment patterns are active-low, bit0 = a ... bit6 = g.
package bcd_display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADJ,
        SHF,
        DONE
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

endpackage

// File: rtl/bcd_display_seq_seg7_decode.sv
// Combinational BCD nibble to active-low seven-segment decoder.
// Nibbles above 9 decode to a dark display.
module seg7_decode
    import bcd_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_display_seq.sv
// Multi-cycle double-dabble binary-to-BCD converter driving DIGITS HEX displays,
// with optional leading-zero blanking.
module bcd_display_seq
    import bcd_display_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 3,
    parameter bit BLANK_LZ = 1'b1
)
(
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   HEX
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t                state, state_next;
    logic [WIDTH-1:0]      shift_reg, shift_next;
    logic [4*DIGITS-1:0]   scratch, scratch_next;
    logic [CW-1:0]         count, count_next;
    logic                  load_out;
    logic [7*DIGITS-1:0]   seg_all;
    logic [7*DIGITS-1:0]   hex_next;
    logic                  higher_nz;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            scratch   <= '0;
            count     <= '0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            scratch   <= scratch_next;
            count     <= count_next;
        end
    end

    // The final shift loads the output registers directly so bcd/HEX are
    // already valid during the DONE cycle alongside the done pulse.
    always_comb begin
        state_next   = state;
        shift_next   = shift_reg;
        scratch_next = scratch;
        count_next   = count;
        load_out     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    shift_next   = bin;
                    scratch_next = '0;
                    count_next   = '0;
                    state_next   = ADJ;
                end
            end
            ADJ: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (scratch[4*i +: 4] >= 4'd5) begin
                        scratch_next[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
                    end
                end
                state_next = SHF;
            end
            SHF: begin
                {scratch_next, shift_next} = {scratch, shift_reg} << 1;
                count_next = count + 1'b1;
                if (count == LAST) begin
                    load_out   = 1'b1;
                    state_next = DONE;
                end else begin
                    state_next = ADJ;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_dec
            seg7_decode u_dec (
                .nibble (scratch_next[4*g +: 4]),
                .seg    (seg_all[7*g +: 7])
            );
        end
    endgenerate

    // Walk from the top digit down; a digit is a leading zero only while
    // nothing above it (or itself) has been non-zero. Digit 0 always shows.
    always_comb begin
        hex_next  = seg_all;
        higher_nz = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            higher_nz = higher_nz | (scratch_next[4*i +: 4] != 4'd0);
            if (BLANK_LZ && (i != 0) && !higher_nz) begin
                hex_next[7*i +: 7] = SEG_BLANK;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            bcd <= '0;
            HEX <= '1;
        end else if (load_out) begin
            bcd <= scratch_next;
            HEX <= hex_next;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule
